// File: rtl/sdl_head_pkg.sv
// Shared constants for the SDL downlink header (inserter and stripper).
// Byte offsets index into the 44-byte LVDS/JJM header; multi-byte fields are MSB first.
package sdl_head_pkg;

    localparam logic [15:0] LVDS_HEAD_LEN = 16'd44;
    localparam logic [15:0] JJM_HEAD_LEN  = 16'd38;
    localparam logic [15:0] CFG_OFS       = 16'd32;
    localparam logic [15:0] MAX_FRAME_LEN = 16'd1024;

    localparam logic [15:0] SYNC_HEAD    = 16'hEB90;
    localparam logic [15:0] CHANNEL_MANG = 16'h520A;

    localparam logic [15:0] OFS_FRAME_TYPE = 16'd0;
    localparam logic [15:0] OFS_ZERO       = 16'd1;
    localparam logic [15:0] OFS_TOTAL_LEN  = 16'd2;
    localparam logic [15:0] OFS_SEG_LEN    = 16'd4;
    localparam logic [15:0] OFS_TIME_STAMP = 16'd6;
    localparam logic [15:0] OFS_SATEL_ID   = 16'd12;
    localparam logic [15:0] OFS_BEAM_ID    = 16'd13;
    localparam logic [15:0] OFS_SYNC       = 16'd14;
    localparam logic [15:0] OFS_CFG_LEN    = 16'd16;
    localparam logic [15:0] OFS_CONTI      = 16'd18;
    localparam logic [15:0] OFS_CHANNEL    = 16'd20;
    localparam logic [15:0] OFS_DATA_TYPE  = 16'd22;
    localparam logic [15:0] OFS_FILLER     = 16'd23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_PAYLOAD,
        ST_TAIL,
        ST_DROP
    } state_t;

endpackage

// File: rtl/sdl_head_check.sv
// Header field capture and validation. hdr_bad is the sticky flag merged with
// the check on the current byte, so the caller can decide on the last header byte.
module sdl_head_check
    import sdl_head_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic [15:0] byte_idx,
    input  logic        byte_en,
    output logic [7:0]  frame_type,
    output logic [7:0]  data_type,
    output logic [15:0] total_len,
    output logic [15:0] conti_cnt,
    output logic        hdr_bad
);

    logic [7:0]  prev_byte_q, prev_byte_d;
    logic [7:0]  frame_type_q, frame_type_d;
    logic [7:0]  data_type_q, data_type_d;
    logic [15:0] total_len_q, total_len_d;
    logic [15:0] conti_q, conti_d;
    logic [47:0] time_stamp_q, time_stamp_d;
    logic [7:0]  satel_id_q, satel_id_d;
    logic [7:0]  beam_id_q, beam_id_d;
    logic        bad_q, bad_d;
    logic [15:0] field16;
    logic        fail;

    // Two-byte fields complete on their odd offset, combining the held MSB.
    assign field16 = {prev_byte_q, byte_in};

    always_comb begin
        fail = 1'b0;
        case (byte_idx)
            OFS_ZERO:             fail = (byte_in != 8'h00);
            OFS_TOTAL_LEN + 16'd1: fail = (field16 < JJM_HEAD_LEN) ||
                                         (field16 > JJM_HEAD_LEN + MAX_FRAME_LEN);
            OFS_SEG_LEN + 16'd1:   fail = (field16 != total_len_q);
            OFS_SYNC + 16'd1:      fail = (field16 != SYNC_HEAD);
            OFS_CFG_LEN + 16'd1:   fail = (field16 != total_len_q - (JJM_HEAD_LEN - CFG_OFS));
            OFS_CHANNEL + 16'd1:   fail = (field16 != CHANNEL_MANG);
            default: begin
                if (byte_idx >= OFS_FILLER && byte_idx < LVDS_HEAD_LEN) begin
                    fail = (byte_in != 8'(byte_idx - OFS_FILLER));
                end
            end
        endcase
    end

    always_comb begin
        prev_byte_d  = prev_byte_q;
        frame_type_d = frame_type_q;
        data_type_d  = data_type_q;
        total_len_d  = total_len_q;
        conti_d      = conti_q;
        time_stamp_d = time_stamp_q;
        satel_id_d   = satel_id_q;
        beam_id_d    = beam_id_q;
        bad_d        = bad_q;
        if (byte_en) begin
            prev_byte_d = byte_in;
            bad_d       = (byte_idx == OFS_FRAME_TYPE) ? fail : (bad_q | fail);
            if (byte_idx == OFS_FRAME_TYPE)        frame_type_d = byte_in;
            if (byte_idx == OFS_DATA_TYPE)         data_type_d  = byte_in;
            if (byte_idx == OFS_TOTAL_LEN + 16'd1) total_len_d  = field16;
            if (byte_idx == OFS_CONTI + 16'd1)     conti_d      = field16;
            if (byte_idx == OFS_SATEL_ID)          satel_id_d   = byte_in;
            if (byte_idx == OFS_BEAM_ID)           beam_id_d    = byte_in;
            if (byte_idx >= OFS_TIME_STAMP && byte_idx < OFS_SATEL_ID) begin
                time_stamp_d = {time_stamp_q[39:0], byte_in};
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_byte_q  <= '0;
            frame_type_q <= '0;
            data_type_q  <= '0;
            total_len_q  <= '0;
            conti_q      <= '0;
            time_stamp_q <= '0;
            satel_id_q   <= '0;
            beam_id_q    <= '0;
            bad_q        <= 1'b0;
        end else begin
            prev_byte_q  <= prev_byte_d;
            frame_type_q <= frame_type_d;
            data_type_q  <= data_type_d;
            total_len_q  <= total_len_d;
            conti_q      <= conti_d;
            time_stamp_q <= time_stamp_d;
            satel_id_q   <= satel_id_d;
            beam_id_q    <= beam_id_d;
            bad_q        <= bad_d;
        end
    end

    assign frame_type = frame_type_q;
    assign data_type  = data_type_q;
    assign total_len  = total_len_q;
    assign conti_cnt  = conti_q;
    assign hdr_bad    = bad_q | (byte_en & fail);

endmodule

// File: rtl/sdl_strip_head.sv
// Strips and validates the 44-byte LVDS/JJM header from each vld run and
// forwards the payload with recovered type/length; bad frames are dropped whole.
module sdl_strip_head
    import sdl_head_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [7:0]  lvds_data,
    input  logic        lvds_data_vld,
    output logic [7:0]  frame_data,
    output logic        frame_data_vld,
    output logic [7:0]  frame_type,
    output logic [7:0]  data_type,
    output logic [15:0] frame_len,
    output logic        frame_len_vld,
    output logic [15:0] conti_cnt,
    output logic        frame_done,
    output logic        hdr_err,
    output logic        len_err,
    output logic        seq_err
);

    state_t      state_q, state_d;
    logic [15:0] hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic        first_q, first_d;
    logic [7:0]  frame_data_q, frame_data_d;
    logic        frame_data_vld_q, frame_data_vld_d;
    logic [7:0]  frame_type_q, frame_type_d;
    logic [7:0]  data_type_q, data_type_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic        frame_len_vld_q, frame_len_vld_d;
    logic [15:0] conti_cnt_q, conti_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        hdr_err_q, hdr_err_d;
    logic        len_err_q, len_err_d;
    logic        seq_err_q, seq_err_d;

    logic        chk_en;
    logic [15:0] chk_idx;
    logic [7:0]  chk_frame_type, chk_data_type;
    logic [15:0] chk_total_len, chk_conti;
    logic        chk_bad;

    // Byte 0 arrives while still in IDLE, so the checker sees it there too.
    assign chk_en  = lvds_data_vld && (state_q == ST_IDLE || state_q == ST_HEAD);
    assign chk_idx = (state_q == ST_IDLE) ? 16'd0 : hdr_cnt_q;

    sdl_head_check u_check (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .byte_in    (lvds_data),
        .byte_idx   (chk_idx),
        .byte_en    (chk_en),
        .frame_type (chk_frame_type),
        .data_type  (chk_data_type),
        .total_len  (chk_total_len),
        .conti_cnt  (chk_conti),
        .hdr_bad    (chk_bad)
    );

    always_comb begin
        state_d          = state_q;
        hdr_cnt_d        = hdr_cnt_q;
        pay_cnt_d        = pay_cnt_q;
        first_d          = first_q;
        frame_data_d     = frame_data_q;
        frame_data_vld_d = 1'b0;
        frame_type_d     = frame_type_q;
        data_type_d      = data_type_q;
        frame_len_d      = frame_len_q;
        frame_len_vld_d  = 1'b0;
        conti_cnt_d      = conti_cnt_q;
        frame_done_d     = 1'b0;
        hdr_err_d        = 1'b0;
        len_err_d        = 1'b0;
        seq_err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lvds_data_vld) begin
                    state_d   = ST_HEAD;
                    hdr_cnt_d = 16'd1;
                end
            end
            ST_HEAD: begin
                if (!lvds_data_vld) begin
                    hdr_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (hdr_cnt_q == LVDS_HEAD_LEN - 16'd1) begin
                    if (chk_bad) begin
                        hdr_err_d = 1'b1;
                        state_d   = ST_DROP;
                    end else begin
                        frame_len_vld_d = 1'b1;
                        frame_type_d    = chk_frame_type;
                        data_type_d     = chk_data_type;
                        frame_len_d     = chk_total_len - JJM_HEAD_LEN;
                        conti_cnt_d     = chk_conti;
                        seq_err_d       = !first_q && (chk_conti != conti_cnt_q + 16'd1);
                        first_d         = 1'b0;
                        pay_cnt_d       = 16'd0;
                        if (chk_total_len == JJM_HEAD_LEN) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_TAIL;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 16'd1;
                end
            end
            ST_PAYLOAD: begin
                if (!lvds_data_vld) begin
                    len_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    frame_data_d     = lvds_data;
                    frame_data_vld_d = 1'b1;
                    pay_cnt_d        = pay_cnt_q + 16'd1;
                    if (pay_cnt_q + 16'd1 == frame_len_q) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (!lvds_data_vld) begin
                    state_d = ST_IDLE;
                end else begin
                    len_err_d = 1'b1;
                    state_d   = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!lvds_data_vld) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            hdr_cnt_q        <= '0;
            pay_cnt_q        <= '0;
            first_q          <= 1'b1;
            frame_data_q     <= '0;
            frame_data_vld_q <= 1'b0;
            frame_type_q     <= '0;
            data_type_q      <= '0;
            frame_len_q      <= '0;
            frame_len_vld_q  <= 1'b0;
            conti_cnt_q      <= '0;
            frame_done_q     <= 1'b0;
            hdr_err_q        <= 1'b0;
            len_err_q        <= 1'b0;
            seq_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            hdr_cnt_q        <= hdr_cnt_d;
            pay_cnt_q        <= pay_cnt_d;
            first_q          <= first_d;
            frame_data_q     <= frame_data_d;
            frame_data_vld_q <= frame_data_vld_d;
            frame_type_q     <= frame_type_d;
            data_type_q      <= data_type_d;
            frame_len_q      <= frame_len_d;
            frame_len_vld_q  <= frame_len_vld_d;
            conti_cnt_q      <= conti_cnt_d;
            frame_done_q     <= frame_done_d;
            hdr_err_q        <= hdr_err_d;
            len_err_q        <= len_err_d;
            seq_err_q        <= seq_err_d;
        end
    end

    assign frame_data     = frame_data_q;
    assign frame_data_vld = frame_data_vld_q;
    assign frame_type     = frame_type_q;
    assign data_type      = data_type_q;
    assign frame_len      = frame_len_q;
    assign frame_len_vld  = frame_len_vld_q;
    assign conti_cnt      = conti_cnt_q;
    assign frame_done     = frame_done_q;
    assign hdr_err        = hdr_err_q;
    assign len_err        = len_err_q;
    assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_sdl_strip_head.sv
// Bench for sdl_strip_head: directed and random byte runs, each compared
// against a frame-level reference model that decodes the run from the header rules.
module tb_sdl_strip_head;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  lvds_data = 8'h00;
    logic        lvds_data_vld = 1'b0;
    logic [7:0]  frame_data;
    logic        frame_data_vld;
    logic [7:0]  frame_type;
    logic [7:0]  data_type;
    logic [15:0] frame_len;
    logic        frame_len_vld;
    logic [15:0] conti_cnt;
    logic        frame_done;
    logic        hdr_err;
    logic        len_err;
    logic        seq_err;

    sdl_strip_head dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .lvds_data      (lvds_data),
        .lvds_data_vld  (lvds_data_vld),
        .frame_data     (frame_data),
        .frame_data_vld (frame_data_vld),
        .frame_type     (frame_type),
        .data_type      (data_type),
        .frame_len      (frame_len),
        .frame_len_vld  (frame_len_vld),
        .conti_cnt      (conti_cnt),
        .frame_done     (frame_done),
        .hdr_err        (hdr_err),
        .len_err        (len_err),
        .seq_err        (seq_err)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    // Output monitor: sole writer of these counters and the payload queue.
    int          m_lv = 0, m_done = 0, m_hdr = 0, m_len = 0, m_seq = 0, m_done_alone = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  m_ft = 0, m_dt = 0;
    logic [15:0] m_fl = 0, m_cc = 0;

    always @(negedge sys_clk) begin
        if (frame_data_vld) got_q.push_back(frame_data);
        if (frame_len_vld) begin
            m_lv++;
            m_ft = frame_type;
            m_dt = data_type;
            m_fl = frame_len;
            m_cc = conti_cnt;
        end
        if (frame_done) begin
            m_done++;
            if (!(frame_data_vld || frame_len_vld)) m_done_alone++;
        end
        if (hdr_err) m_hdr++;
        if (len_err) m_len++;
        if (seq_err) m_seq++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [7:0]  fq[$];
    bit          r_first = 1'b1;
    logic [15:0] r_prev = 16'h0;

    task automatic build(input logic [7:0] ft, input logic [7:0] dt, input logic [15:0] conti,
                         input logic [15:0] total, input int npay, input int cidx,
                         input logic [7:0] cxor);
        logic [15:0] cfg;
        cfg = total - 16'd6;
        fq.delete();
        fq.push_back(ft);              fq.push_back(8'h00);
        fq.push_back(total[15:8]);     fq.push_back(total[7:0]);
        fq.push_back(total[15:8]);     fq.push_back(total[7:0]);
        for (int i = 0; i < 8; i++) fq.push_back(8'($urandom));
        fq.push_back(8'hEB);           fq.push_back(8'h90);
        fq.push_back(cfg[15:8]);       fq.push_back(cfg[7:0]);
        fq.push_back(conti[15:8]);     fq.push_back(conti[7:0]);
        fq.push_back(8'h52);           fq.push_back(8'h0A);
        fq.push_back(dt);
        for (int i = 23; i < 44; i++) fq.push_back(8'(i - 23));
        for (int i = 0; i < npay; i++) fq.push_back(8'($urandom));
        if (cidx >= 0 && cidx < fq.size()) fq[cidx] = fq[cidx] ^ cxor;
    endtask

    task automatic drive_bytes(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge sys_clk); #1;
            lvds_data     = fq[i];
            lvds_data_vld = 1'b1;
        end
    endtask

    task automatic run_frame(input string name, input int gap);
        int s_lv, s_done, s_hdr, s_len, s_seq, s_alone, s_got;
        int n, np;
        bit ok;
        int e_hdr, e_acc, e_done, e_len, e_seq;
        logic [15:0] total, conti, elen;
        logic [7:0]  e_pay[$];
        s_lv = m_lv; s_done = m_done; s_hdr = m_hdr; s_len = m_len; s_seq = m_seq;
        s_alone = m_done_alone; s_got = got_q.size();
        drive_bytes(fq.size());
        @(posedge sys_clk); #1;
        lvds_data_vld = 1'b0;
        lvds_data     = 8'h00;
        repeat (gap) @(negedge sys_clk);
        #1;
        // Frame-level decode of the run just sent.
        n = fq.size();
        e_hdr = 0; e_acc = 0; e_done = 0; e_len = 0; e_seq = 0; elen = 0; conti = 0;
        e_pay.delete();
        if (n < 44) begin
            e_hdr = 1;
        end else begin
            total = {fq[2], fq[3]};
            ok = (fq[1] == 8'h00) && ({fq[4], fq[5]} == total) &&
                 ({fq[14], fq[15]} == 16'hEB90) && ({fq[20], fq[21]} == 16'h520A) &&
                 (int'({fq[16], fq[17]}) == int'(total) - 6) &&
                 (int'(total) >= 38) && (int'(total) <= 38 + 1024);
            for (int i = 23; i < 44; i++) if (fq[i] != 8'(i - 23)) ok = 1'b0;
            if (!ok) begin
                e_hdr = 1;
            end else begin
                e_acc = 1;
                elen  = total - 16'd38;
                conti = {fq[18], fq[19]};
                e_seq = (!r_first && conti != 16'(r_prev + 16'd1)) ? 1 : 0;
                r_first = 1'b0;
                r_prev  = conti;
                np = n - 44;
                for (int i = 0; i < np && i < int'(elen); i++) e_pay.push_back(fq[44 + i]);
                e_done = (np >= int'(elen)) ? 1 : 0;
                e_len  = (np != int'(elen)) ? 1 : 0;
            end
        end
        chk({name, ".hdr_err"},       m_hdr - s_hdr, e_hdr);
        chk({name, ".frame_len_vld"}, m_lv - s_lv, e_acc);
        chk({name, ".frame_done"},    m_done - s_done, e_done);
        chk({name, ".len_err"},       m_len - s_len, e_len);
        chk({name, ".seq_err"},       m_seq - s_seq, e_seq);
        chk({name, ".done_align"},    m_done_alone - s_alone, 0);
        chk({name, ".n_bytes"},       got_q.size() - s_got, e_pay.size());
        for (int i = 0; i < e_pay.size() && s_got + i < got_q.size(); i++) begin
            chk($sformatf("%s.byte%0d", name, i), got_q[s_got + i], e_pay[i]);
        end
        if (e_acc == 1) begin
            chk({name, ".frame_len"},  m_fl, elen);
            chk({name, ".frame_type"}, m_ft, fq[0]);
            chk({name, ".data_type"},  m_dt, fq[22]);
            chk({name, ".conti_cnt"},  m_cc, conti);
        end
        $display("frame %s: bytes=%0d hdr_err=%0d accept=%0d done=%0d len_err=%0d seq_err=%0d",
                 name, n, e_hdr, e_acc, e_done, e_len, e_seq);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, ".ctl"}, {frame_data, frame_data_vld, frame_type, data_type, frame_len_vld,
                             frame_done, hdr_err, len_err, seq_err}, 32'h0);
        chk({name, ".len_conti"}, {frame_len, conti_cnt}, 32'h0);
    endtask

    initial begin
        int len, npay, mode, cidx;
        logic [15:0] cval;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        build(8'h11, 8'h22, 16'd5, 16'd42, 4, -1, 8'h00);    run_frame("nominal", 3);
        build(8'h33, 8'h44, 16'd6, 16'd42, 4, 15, 8'h01);    run_frame("bad_sync", 3);
        build(8'h33, 8'h44, 16'd6, 16'd42, 4, -1, 8'h00);    run_frame("after_bad", 3);
        build(8'h55, 8'h66, 16'd7, 16'd42, 2, -1, 8'h00);    run_frame("short_pay", 3);
        build(8'h01, 8'h02, 16'd8, 16'd38, 0, -1, 8'h00);    run_frame("len0", 1);
        build(8'h03, 8'h04, 16'd9, 16'd41, 3, -1, 8'h00);    run_frame("len3", 3);
        build(8'h05, 8'h06, 16'd10, 16'd41, 5, -1, 8'h00);   run_frame("long_pay", 3);
        build(8'h07, 8'h08, 16'd11, 16'd37, 0, -1, 8'h00);   run_frame("total_37", 3);
        build(8'h07, 8'h08, 16'd11, 16'd1063, 3, -1, 8'h00); run_frame("total_1063", 3);
        build(8'h07, 8'h08, 16'd11, 16'd60, 5, 17, 8'h01);   run_frame("bad_cfg", 3);
        build(8'h07, 8'h08, 16'd11, 16'd60, 5, 40, 8'h80);   run_frame("bad_filler", 3);
        build(8'h09, 8'h0A, 16'd11, 16'd1062, 1024, -1, 8'h00); run_frame("max_len", 3);

        // Asynchronous reset during payload byte 2 of a 10-byte frame.
        build(8'h21, 8'h31, 16'd12, 16'd48, 10, -1, 8'h00);
        drive_bytes(47);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        lvds_data_vld = 1'b0;
        lvds_data     = 8'h00;
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        r_first = 1'b1;
        repeat (2) @(posedge sys_clk);
        build(8'hA1, 8'hB2, 16'hFFFD, 16'd43, 5, -1, 8'h00); run_frame("post_reset", 3);

        build(8'h10, 8'h20, 16'hFFFE, 16'd39, 1, -1, 8'h00); run_frame("conti_fffe", 3);
        build(8'h10, 8'h20, 16'hFFFF, 16'd39, 1, -1, 8'h00); run_frame("conti_ffff", 3);
        build(8'h10, 8'h20, 16'h0000, 16'd39, 1, -1, 8'h00); run_frame("conti_0000", 3);
        build(8'h10, 8'h20, 16'h0002, 16'd39, 1, -1, 8'h00); run_frame("conti_0002", 3);

        for (int k = 0; k < 30; k++) begin
            len  = $urandom_range(0, 12);
            mode = $urandom_range(0, 5);
            cval = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(r_prev + 16'd1);
            npay = len;
            cidx = -1;
            if (mode == 0) cidx = $urandom_range(0, 43);
            if (mode == 1) npay = len + $urandom_range(1, 3);
            if (mode == 2 && len > 0) npay = $urandom_range(0, len - 1);
            build(8'($urandom), 8'($urandom), cval, 16'(38 + len), npay, cidx,
                  8'($urandom_range(1, 255)));
            if (mode == 3) begin
                while (fq.size() > 1 && fq.size() > $urandom_range(1, 43)) void'(fq.pop_back());
            end
            run_frame($sformatf("rand%0d", k), 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
